// File: rtl/spi_target_regs_if.sv
// rtl/spi_target_regs_if.sv - SPI pin bundle between a master and the register target
interface spi_target_regs_if;
    logic sck;
    logic mosi;
    logic cs;
    logic miso;
    logic miso_oe;

    modport master (
        output sck,
        output mosi,
        output cs,
        input  miso,
        input  miso_oe
    );

    modport slave (
        input  sck,
        input  mosi,
        input  cs,
        output miso,
        output miso_oe
    );
endinterface

// File: rtl/spi_target_regs.sv
// rtl/spi_target_regs.sv - oversampled SPI mode-0 target serving a byte register file
module spi_target_regs #(
    parameter int          REGS    = 16,
    parameter logic [7:0]  RST_VAL = 8'h00,
    localparam int         AW      = $clog2(REGS)
) (
    input  logic          clk,
    input  logic          rst,
    spi_target_regs_if.slave spi,
    output logic          wr_stb,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    input  logic [AW-1:0] host_addr,
    output logic [7:0]    host_rdata,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

    state_t        state, state_nx;
    logic          sck_s1, sck_s2, sck_s3;
    logic          mosi_s1, mosi_s2;
    logic          cs_s1, cs_s2;
    logic [1:0]    sync_ok;
    logic          armed;
    logic          rise, fall, byte_done;
    logic [2:0]    bit_cnt;
    logic [7:0]    sh_in, sh_out, rx_byte;
    logic [AW-1:0] addr;
    logic          wr_pend;
    logic [7:0]    regs [REGS];

    assign rise      = sck_s2 & ~sck_s3;
    assign fall      = ~sck_s2 & sck_s3;
    assign byte_done = rise && (bit_cnt == 3'd7);
    assign rx_byte   = {sh_in[6:0], mosi_s2};
    assign busy      = (state != IDLE);

    // armed only after a genuine high cs sample, so a cs held low through reset is not a frame start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_s3  <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            sync_ok <= 2'b00;
            armed   <= 1'b0;
        end else begin
            sck_s1  <= spi.sck;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            mosi_s1 <= spi.mosi;
            mosi_s2 <= mosi_s1;
            cs_s1   <= spi.cs;
            cs_s2   <= cs_s1;
            sync_ok <= {sync_ok[0], 1'b1};
            armed   <= armed | (sync_ok[1] & cs_s2);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (armed && !cs_s2) state_nx = CMD;
            CMD: begin
                if (cs_s2)          state_nx = IDLE;
                else if (byte_done) state_nx = rx_byte[7] ? RDATA : WDATA;
            end
            WDATA: if (cs_s2) state_nx = IDLE;
            RDATA: if (cs_s2) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= 3'd0;
            sh_in   <= 8'h00;
            sh_out  <= 8'h00;
            addr    <= '0;
            wr_pend <= 1'b0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            wr_data <= 8'h00;
            spi.miso    <= 1'b0;
            spi.miso_oe <= 1'b0;
        end else begin
            if (state == IDLE) begin
                bit_cnt <= 3'd0;
            end else if (rise) begin
                sh_in   <= rx_byte;
                bit_cnt <= bit_cnt + 3'd1;
            end

            wr_pend <= (state == WDATA) && byte_done;
            wr_stb  <= wr_pend;
            if (wr_pend) begin
                wr_addr <= addr;
                wr_data <= sh_in;
            end

            if (state == CMD && byte_done)
                addr <= rx_byte[AW-1:0];
            else if (wr_pend)
                addr <= addr + AW'(1);
            else if (state == RDATA && fall && bit_cnt == 3'd0)
                addr <= addr + AW'(1);

            // the fall that closes a byte (bit_cnt back at 0) fetches the next one
            if (state != RDATA)
                sh_out <= 8'h00;
            else if (fall)
                sh_out <= (bit_cnt == 3'd0) ? regs[addr] : {sh_out[6:0], 1'b0};

            spi.miso_oe <= ~cs_s1;
            spi.miso    <= ~cs_s1 && (state == RDATA) && sh_out[7];
        end
    end

    // regs commit at the end of the wr_stb cycle, so a same-cycle host read sees the old value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REGS; i++) regs[i] <= RST_VAL;
            host_rdata <= 8'h00;
        end else begin
            if (wr_stb) regs[wr_addr] <= wr_data;
            host_rdata <= regs[host_addr];
        end
    end
endmodule

// File: tb/tb_spi_target_regs.sv
// tb/tb_spi_target_regs.sv - directed SPI frames with a write-event scoreboard
module tb_spi_target_regs;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_stb;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [AW-1:0] host_addr;
    logic [7:0]    host_rdata;
    logic          busy;

    spi_target_regs_if spi();

    spi_target_regs dut (
        .clk       (clk),
        .rst       (rst),
        .spi       (spi),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .host_addr (host_addr),
        .host_rdata(host_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int stb_count = 0;
    logic [AW+7:0] exp_wr[$];
    logic [7:0] rxb [3];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // write-event monitor: every wr_stb must match the oldest expected write
    always @(negedge clk) begin
        if (rst === 1'b1 && wr_stb === 1'b1) begin
            logic [AW+7:0] e;
            n_checks++;
            stb_count++;
            if (exp_wr.size() == 0) begin
                n_fail++;
                $display("FAIL wr_event: got addr %0h data %02h, required no write", wr_addr, wr_data);
            end else begin
                e = exp_wr.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    n_fail++;
                    $display("FAIL wr_event: got addr %0h data %02h, required addr %0h data %02h",
                             wr_addr, wr_data, e[AW+7:8], e[7:0]);
                end
            end
        end
    end

    task automatic expect_wr(input logic [AW-1:0] a, input logic [7:0] d);
        exp_wr.push_back({a, d});
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi.mosi = tx[7-i];
            wait_clk(4);
            rx = {rx[6:0], spi.miso};
            spi.sck = 1'b1;
            wait_clk(4);
            spi.sck = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int n);
        logic [7:0] tx [3];
        logic [7:0] r;
        tx[0] = b0; tx[1] = b1; tx[2] = b2;
        spi.cs = 1'b0;
        wait_clk(4);
        for (int i = 0; i < n; i++) begin
            spi_bits(tx[i], 8, r);
            rxb[i] = r;
        end
        wait_clk(4);
        spi.cs = 1'b1;
        wait_clk(8);
    endtask

    task automatic host_read(input string name, input logic [AW-1:0] a, input logic [7:0] exp);
        host_addr = a;
        wait_clk(1);
        chk(name, {24'h0, host_rdata}, {24'h0, exp});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int snap;
        logic [7:0] r;
        logic [7:0] tail;
        rst = 1'b0;
        spi.sck = 1'b0;
        spi.mosi = 1'b0;
        spi.cs = 1'b1;
        host_addr = '0;
        wait_clk(3);
        chk("rst_miso", {31'h0, spi.miso}, 32'h0);
        chk("rst_miso_oe", {31'h0, spi.miso_oe}, 32'h0);
        chk("rst_wr_stb", {31'h0, wr_stb}, 32'h0);
        chk("rst_wr_addr", {28'h0, wr_addr}, 32'h0);
        chk("rst_wr_data", {24'h0, wr_data}, 32'h0);
        chk("rst_host_rdata", {24'h0, host_rdata}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        rst = 1'b1;
        wait_clk(6);

        // write burst
        expect_wr(4'd3, 8'hA5);
        expect_wr(4'd4, 8'h5A);
        spi_frame(8'h03, 8'hA5, 8'h5A, 3);
        host_read("burst_r3", 4'd3, 8'hA5);
        host_read("burst_r4", 4'd4, 8'h5A);
        host_read("burst_r5", 4'd5, 8'h00);

        // read back a preloaded register
        expect_wr(4'd7, 8'hC3);
        spi_frame(8'h07, 8'hC3, 8'h00, 2);
        snap = stb_count;
        spi_frame(8'h87, 8'h00, 8'h00, 3);
        chk("read_cmd_byte", {24'h0, rxb[0]}, 32'h00);
        chk("read_r7", {24'h0, rxb[1]}, 32'hC3);
        chk("read_r8", {24'h0, rxb[2]}, 32'h00);
        chk("read_no_stb", stb_count, snap);

        // address wrap
        expect_wr(4'd15, 8'h11);
        expect_wr(4'd0, 8'h22);
        spi_frame(8'h0F, 8'h11, 8'h22, 3);
        host_read("wrap_r15", 4'd15, 8'h11);
        host_read("wrap_r0", 4'd0, 8'h22);
        spi_frame(8'h8F, 8'h00, 8'h00, 3);
        chk("wrap_read_r15", {24'h0, rxb[1]}, 32'h11);
        chk("wrap_read_r0", {24'h0, rxb[2]}, 32'h22);

        // abort mid data byte
        snap = stb_count;
        spi.cs = 1'b0;
        wait_clk(4);
        spi_bits(8'h02, 8, r);
        spi_bits(8'hFF, 5, r);
        wait_clk(3);
        chk("abort_busy_before", {31'h0, busy}, 32'h1);
        spi.cs = 1'b1;
        wait_clk(3);
        chk("abort_busy_drop", {31'h0, busy}, 32'h0);
        wait_clk(8);
        chk("abort_no_stb", stb_count, snap);
        host_read("abort_r2", 4'd2, 8'h00);
        expect_wr(4'd2, 8'h3C);
        spi_frame(8'h02, 8'h3C, 8'h00, 2);
        host_read("abort_after_r2", 4'd2, 8'h3C);

        // host read colliding with an SPI write
        host_addr = 4'd9;
        wait_clk(2);
        expect_wr(4'd9, 8'h77);
        fork
            spi_frame(8'h09, 8'h77, 8'h00, 2);
            begin
                int k;
                k = 0;
                while (wr_stb !== 1'b1 && k < 2000) begin
                    wait_clk(1);
                    k++;
                end
                if (k >= 2000) begin
                    chk("coll_wait", 32'h0, 32'h1);
                end else begin
                    wait_clk(1);
                    chk("coll_old", {24'h0, host_rdata}, 32'h00);
                    wait_clk(1);
                    chk("coll_new", {24'h0, host_rdata}, 32'h77);
                end
            end
        join

        // reset in the middle of a write data byte
        snap = stb_count;
        host_addr = 4'd3;
        spi.cs = 1'b0;
        wait_clk(4);
        spi_bits(8'h03, 8, r);
        spi_bits(8'hEE, 3, r);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        chk("mid_rst_wr_addr", {28'h0, wr_addr}, 32'h0);
        chk("mid_rst_wr_data", {24'h0, wr_data}, 32'h0);
        chk("mid_rst_host_rdata", {24'h0, host_rdata}, 32'h0);
        chk("mid_rst_miso_oe", {31'h0, spi.miso_oe}, 32'h0);
        wait_clk(3);
        rst = 1'b1;
        tail = 8'hEE << 3;
        spi_bits(tail, 5, r);
        wait_clk(3);
        chk("mid_rst_idle", {31'h0, busy}, 32'h0);
        spi.cs = 1'b1;
        wait_clk(8);
        chk("mid_rst_no_stb", stb_count, snap);
        host_read("mid_rst_r3", 4'd3, 8'h00);
        host_read("mid_rst_r9", 4'd9, 8'h00);
        expect_wr(4'd4, 8'h99);
        spi_frame(8'h04, 8'h99, 8'h00, 2);
        host_read("post_rst_r4", 4'd4, 8'h99);

        wait_clk(4);
        chk("exp_wr_drained", exp_wr.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_target_regs.md
# spi_target_regs

SPI mode-0 target (peripheral) with an internal byte register file; the far end of the SPI master inside `rfid_top`. It is used as an on-board or simulation stand-in for an external SPI device on one chip-select line, so that master transactions can be exercised and checked. It oversamples `sck`, `mosi` and `cs` in the system clock domain, decodes command frames, and serves register writes and reads. A host port exposes the register contents and write events to surrounding logic and test benches.

## Interface
- `REGS`, default 16: register count, a power of two, 2..128. Address width `AW = log2(REGS)`.
- `RST_VAL`, default 8'h00: reset value of every register.
- `clk` input 1: system clock, 50 MHz on the FPGA board.
- `rst` input 1: reset, asynchronous, active-low.
- `sck` input 1: SPI clock from the master; asynchronous to `clk`.
- `mosi` input 1: SPI data from the master.
- `cs` input 1: chip select, active-low.
- `miso` output 1: SPI data to the master; 0 whenever `miso_oe` is 0.
- `miso_oe` output 1: output enable for an external tri-state buffer; 1 while the synchronized `cs` is low.
- `wr_stb` output 1: one-cycle pulse when a register is written over SPI.
- `wr_addr` output AW: address of the last SPI write.
- `wr_data` output 8: data of the last SPI write.
- `host_addr` input AW: host read address.
- `host_rdata` output 8: `regs[host_addr]`, registered with 1-cycle latency.
- `busy` output 1: 1 while a frame is in progress (state is not IDLE).

## Operation
- Protocol: CPOL=0, CPHA=0, MSB first. The master shifts on falling `sck` and samples on rising `sck`.
- Frame format: byte 0 is the command `{rw, a[6:0]}`, where `rw`=1 means read. Address = `a[AW-1:0]`; upper address bits are ignored.
- The bytes that follow are data bytes. Bursts are unlimited. The address auto-increments after each data byte, modulo `REGS`.
- Synchronization: `sck`, `mosi` and `cs` each pass through 2 flops. A third flop on `sck` detects edges, producing `rise` and `fall` pulses.
- States:
  - IDLE: `cs`_s high.
  - CMD: shifting in the command byte.
  - WDATA: shifting in write data bytes.
  - RDATA: shifting out read data bytes.
- Transitions:
  - IDLE→CMD when `cs`_s falls; `bit_cnt` is cleared.
  - CMD→WDATA or CMD→RDATA on the 8th `rise`; the choice is made by `rw`.
  - Any state→IDLE when `cs`_s goes high.
- Receive path: on each `rise`, `mosi`_s is shifted into `sh_in` and `bit_cnt` increments modulo 8.
- Write handling: on the 8th `rise` in WDATA, in the next cycle:
  - `regs[addr]` ← byte.
  - `wr_addr`/`wr_data` are updated.
  - `wr_stb` = 1.
  - `addr` increments.
- Read handling:
  - On each `fall` in RDATA, if `bit_cnt`==0, `sh_out` ← `regs[addr]` and `addr` increments; otherwise `sh_out` shifts left.
  - `miso` = `sh_out[7]`, registered.
  - In CMD, `miso` = 0.
- Abort: `cs`_s going high mid-byte discards the partial byte. No write and no `wr_stb` occur, and the state returns to IDLE.
- Collision: a host read of an address written in the same cycle returns the old value.
- Reset: every `regs` entry = `RST_VAL`. All outputs are 0: `miso`, `miso_oe`, `wr_stb`, `wr_addr`, `wr_data`, `host_rdata`, `busy`. State = IDLE and synchronizers = idle levels (`sck`=0, `cs`=1).
- Reset asserted mid-frame: the block returns to IDLE immediately. While `cs` remains low after reset release, it waits for a fresh `cs` falling edge before decoding anything.

## Timing
- Input-to-internal latency: 2 `clk` for synchronization. `rise`/`fall` are valid in the 3rd cycle after the pin edge.
- `wr_stb` asserts 4 `clk` after the 8th rising `sck` edge of a data byte.
- `miso` changes 4 `clk` after a falling `sck` edge, so it is valid before the next rising edge provided the `sck` high and low phases are each ≥ 4 `clk`.
- Supported SCK: ≤ `clk`/8, i.e. 6.25 MHz at 50 MHz.
- Chip select timing: `cs` setup to the first `sck` rise, and `cs` hold after the last `sck` fall, must each be ≥ 3 `clk`.
- `miso_oe` follows `cs` with 2 `clk` latency, asserting and deasserting.
- `host_rdata` latency is 1 `clk`.

## Test plan
- Write burst:
  - Stimulus: frame `0x03,0xA5,0x5A` at SCK = `clk`/8.
  - Response: two `wr_stb` pulses with (3, A5) then (4, 5A); host reads of addr 3 and 4 return A5 and 5A.
- Read:
  - Stimulus: preload reg 7 = 0xC3 via SPI, then frame `0x87,0x00`.
  - Response: master samples 0xC3 on byte 1 and 0x00 on byte 0; no `wr_stb` during the read frame.
- Wrap:
  - Stimulus: write frame `0x0F,0x11,0x22` with `REGS`=16.
  - Response: reg 15 = 11 and reg 0 = 22.
  - Follow-up: read burst `0x8F,0,0` returns 11 then 22.
- Abort:
  - Stimulus: raise `cs` after 5 bits of a write data byte to addr 2.
  - Response: reg 2 unchanged, no `wr_stb`, `busy` drops within 3 `clk`, and the next full frame decodes correctly.
- Reset mid-frame:
  - Stimulus: assert `rst` during byte 1 of a write.
  - Response: all outputs 0 and all regs = `RST_VAL` immediately; no write completes. After release, a new frame works.
- Host collision:
  - Stimulus: set `host_addr` = the SPI write target during the `wr_stb` cycle.
  - Response: `host_rdata` shows the old value in the next cycle and the new value one cycle later.
